// File: rtl/alu_ops_pkg.sv
// Shared ALU opcode constants, issue FSM states and opcode classification helpers
// for the ALU sequencing front end.
package alu_ops_pkg;

  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB_LO = 2'd2,
    ST_WB_HI = 2'd3
  } issue_state_t;

  // Multiply and divide produce a full 64-bit result returned as LO then HI.
  function automatic logic is_two_beat(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_known_op(input logic [4:0] op);
    logic known;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SHR, OP_SHRA,
      OP_SHL, OP_ROR, OP_ROL, OP_NEG, OP_NOT, OP_NOP: known = 1'b1;
      default:                                        known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/alu_z_reg.sv
// 64-bit (by default) ALU result register Z: loads on enable, cleared
// asynchronously.
module alu_z_reg #(
  parameter int W = 64
) (
  input  logic         i_clock,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_z;

  always_ff @(posedge i_clock or posedge i_clear) begin
    if (i_clear)     r_z <= '0;
    else if (i_load) r_z <= i_d;
  end

  assign o_q = r_z;

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue front end: latches one request, runs it through the combinational
// ALU for one cycle, then returns the captured result as one or two write-back beats.
module alu_issue_ctrl
  import alu_ops_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 4
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4:0]            req_opcode,
  input  logic                  req_incpc,
  input  logic [WIDTH-1:0]      req_a,
  input  logic [WIDTH-1:0]      req_b,
  input  logic [REG_BITS-1:0]   req_dest,
  output logic [4:0]            alu_opcode,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic                  alu_incpc,
  input  logic [2*WIDTH-1:0]    alu_result,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [WIDTH-1:0]      wb_data,
  output logic [REG_BITS-1:0]   wb_dest,
  output logic                  wb_hi,
  output logic                  busy
);

  issue_state_t          r_state;
  issue_state_t          w_next;
  logic [4:0]            r_opcode;
  logic                  r_incpc;
  logic [WIDTH-1:0]      r_a;
  logic [WIDTH-1:0]      r_b;
  logic [REG_BITS-1:0]   r_dest;
  logic                  w_accept;
  logic                  w_z_load;
  logic [2*WIDTH-1:0]    w_z_d;
  logic [2*WIDTH-1:0]    w_z;

  assign w_accept = (r_state == ST_IDLE) && req_valid;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state  <= ST_IDLE;
      r_opcode <= OP_NOP;
      r_incpc  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_dest   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_opcode <= req_opcode;
        r_incpc  <= req_incpc;
        r_a      <= req_a;
        r_b      <= req_b;
        r_dest   <= req_dest;
      end
    end
  end

  // A PC increment always returns one beat, whatever opcode came with it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (req_valid) w_next = ST_EXEC;
      ST_EXEC:  w_next = (r_opcode == OP_NOP && !r_incpc) ? ST_IDLE : ST_WB_LO;
      ST_WB_LO: if (wb_ready)
                  w_next = (is_two_beat(r_opcode) && !r_incpc) ? ST_WB_HI : ST_IDLE;
      ST_WB_HI: if (wb_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Unknown opcodes must write back zero, so the ALU output is masked before capture.
  assign w_z_load = (r_state == ST_EXEC);
  assign w_z_d    = (r_incpc || is_known_op(r_opcode)) ? alu_result : '0;

  alu_z_reg #(.W(2*WIDTH)) u_z_reg (
    .i_clock (clock),
    .i_clear (clear),
    .i_load  (w_z_load),
    .i_d     (w_z_d),
    .o_q     (w_z)
  );

  always_comb begin
    req_ready = (r_state == ST_IDLE);
    busy      = (r_state != ST_IDLE);
    alu_incpc = (r_state == ST_EXEC) && r_incpc;
    wb_valid  = 1'b0;
    wb_hi     = 1'b0;
    wb_data   = '0;
    wb_dest   = '0;
    case (r_state)
      ST_WB_LO: begin
        wb_valid = 1'b1;
        wb_data  = w_z[WIDTH-1:0];
        wb_dest  = r_dest;
      end
      ST_WB_HI: begin
        wb_valid = 1'b1;
        wb_hi    = 1'b1;
        wb_data  = w_z[2*WIDTH-1:WIDTH];
        wb_dest  = r_dest;
      end
      default: ;
    endcase
  end

  assign alu_opcode = r_opcode;
  assign alu_a      = r_a;
  assign alu_b      = r_b;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed requests push expected write-back
// beats, and a negedge monitor pops and compares every beat the DUT transfers.
module tb_alu_issue_ctrl;
  import alu_ops_pkg::*;

  localparam int WIDTH    = 32;
  localparam int REG_BITS = 4;

  logic                clock = 1'b0;
  logic                clear;
  logic                req_valid;
  logic                req_ready;
  logic [4:0]          req_opcode;
  logic                req_incpc;
  logic [WIDTH-1:0]    req_a;
  logic [WIDTH-1:0]    req_b;
  logic [REG_BITS-1:0] req_dest;
  logic [4:0]          alu_opcode;
  logic [WIDTH-1:0]    alu_a;
  logic [WIDTH-1:0]    alu_b;
  logic                alu_incpc;
  logic [2*WIDTH-1:0]  alu_result;
  logic                wb_valid;
  logic                wb_ready;
  logic [WIDTH-1:0]    wb_data;
  logic [REG_BITS-1:0] wb_dest;
  logic                wb_hi;
  logic                busy;

  typedef struct {
    logic [WIDTH-1:0]    data;
    logic [REG_BITS-1:0] dest;
    logic                hi;
  } beat_t;

  beat_t expQ[$];
  beat_t monBeat;
  int    total = 0;
  int    bad   = 0;

  alu_issue_ctrl #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) dut (
    .clock      (clock),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_incpc  (req_incpc),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_dest   (req_dest),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_incpc  (alu_incpc),
    .alu_result (alu_result),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_data    (wb_data),
    .wb_dest    (wb_dest),
    .wb_hi      (wb_hi),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // Small behavioural ALU; anything it does not model returns a marker pattern.
  always_comb begin
    alu_result = 64'hDEADBEEF_CAFEF00D;
    if (alu_incpc) alu_result = {32'b0, alu_a + 32'd1};
    else begin
      case (alu_opcode)
        OP_ADD: alu_result = {32'b0, alu_a + alu_b};
        OP_SUB: alu_result = {32'b0, alu_a - alu_b};
        OP_MUL: alu_result = {32'b0, alu_a} * {32'b0, alu_b};
        OP_DIV: alu_result = (alu_b == 0) ? 64'h0 : {alu_a % alu_b, alu_a / alu_b};
        OP_NOP: alu_result = 64'h0;
        default: ;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushBeat(input logic [WIDTH-1:0] data, input logic [REG_BITS-1:0] dest,
                          input logic hi);
    beat_t b;
    b.data = data;
    b.dest = dest;
    b.hi   = hi;
    expQ.push_back(b);
  endtask

  // Returns just after the accepting rising edge.
  task automatic applyStimulus(input logic [4:0] op, input logic inc,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [REG_BITS-1:0] dest);
    int waitCycles = 0;
    @(negedge clock);
    while (!req_ready && waitCycles < 50) begin
      @(negedge clock);
      waitCycles++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL req_ready_timeout: got req_ready=0, expected 1");
    end
    req_opcode = op;
    req_incpc  = inc;
    req_a      = a;
    req_b      = b;
    req_dest   = dest;
    req_valid  = 1'b1;
    @(posedge clock);
    #1;
    req_valid  = 1'b0;
    req_a      = 32'hFFFF_FFFF;
    req_b      = 32'hFFFF_FFFF;
  endtask

  task automatic waitIdle();
    int waitCycles = 0;
    @(negedge clock);
    while ((busy || expQ.size() != 0) && waitCycles < 50) begin
      @(negedge clock);
      waitCycles++;
    end
    if (busy || expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL idle_timeout: got busy=%0b pending=%0d, expected idle with 0 pending",
               busy, expQ.size());
    end
  endtask

  // Monitor: a beat transfers on the next rising edge whenever valid and ready are high here.
  initial begin
    forever begin
      @(negedge clock);
      if (!clear && wb_valid && wb_ready) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_beat: got data=0x%0h hi=%0b, expected no beat",
                   wb_data, wb_hi);
        end else begin
          monBeat = expQ.pop_front();
          checkOutput("wb_data", 64'(wb_data), 64'(monBeat.data));
          checkOutput("wb_hi", 64'(wb_hi), 64'(monBeat.hi));
          if (!monBeat.hi) checkOutput("wb_dest", 64'(wb_dest), 64'(monBeat.dest));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    clear      = 1'b1;
    req_valid  = 1'b0;
    req_opcode = OP_NOP;
    req_incpc  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_dest   = '0;
    wb_ready   = 1'b1;
    #2;
    checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("rst_wb_hi", 64'(wb_hi), 64'd0);
    checkOutput("rst_wb_data", 64'(wb_data), 64'd0);
    checkOutput("rst_wb_dest", 64'(wb_dest), 64'd0);
    checkOutput("rst_alu_a", 64'(alu_a), 64'd0);
    checkOutput("rst_alu_b", 64'(alu_b), 64'd0);
    checkOutput("rst_alu_incpc", 64'(alu_incpc), 64'd0);
    checkOutput("rst_alu_opcode", 64'(alu_opcode), 64'(OP_NOP));
    #10;
    clear = 1'b0;

    // add 5+7 -> one beat at N+2, ready again after the transfer
    pushBeat(32'd12, 4'd3, 1'b0);
    applyStimulus(OP_ADD, 1'b0, 32'd5, 32'd7, 4'd3);
    @(negedge clock);
    checkOutput("add_exec_wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("add_exec_busy", 64'(busy), 64'd1);
    checkOutput("add_exec_req_ready", 64'(req_ready), 64'd0);
    checkOutput("add_alu_opcode", 64'(alu_opcode), 64'(OP_ADD));
    checkOutput("add_alu_a", 64'(alu_a), 64'd5);
    checkOutput("add_alu_b", 64'(alu_b), 64'd7);
    @(negedge clock);
    checkOutput("add_wb_valid_n2", 64'(wb_valid), 64'd1);
    @(negedge clock);
    checkOutput("add_ready_after", 64'(req_ready), 64'd1);
    checkOutput("add_alu_a_held", 64'(alu_a), 64'd5);

    // mul 0x10000 * 0x10000 = 0x1_0000_0000 -> LO 0, HI 1 in consecutive cycles
    pushBeat(32'd0, 4'd2, 1'b0);
    pushBeat(32'd1, 4'd2, 1'b1);
    applyStimulus(OP_MUL, 1'b0, 32'h0001_0000, 32'h0001_0000, 4'd2);
    @(negedge clock);
    @(negedge clock);
    checkOutput("mul_lo_hi_flag", 64'(wb_hi), 64'd0);
    @(negedge clock);
    checkOutput("mul_hi_next_cycle", 64'(wb_hi), 64'd1);
    waitIdle();

    // div 17/5 -> LO quotient 3, HI remainder 2
    pushBeat(32'd3, 4'd4, 1'b0);
    pushBeat(32'd2, 4'd4, 1'b1);
    applyStimulus(OP_DIV, 1'b0, 32'd17, 32'd5, 4'd4);
    waitIdle();

    // add 10+20 stalled for 4 cycles with a request pulsed meanwhile
    wb_ready = 1'b0;
    pushBeat(32'd30, 4'd5, 1'b0);
    applyStimulus(OP_ADD, 1'b0, 32'd10, 32'd20, 4'd5);
    @(negedge clock);
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      checkOutput("stall_wb_valid", 64'(wb_valid), 64'd1);
      checkOutput("stall_wb_data", 64'(wb_data), 64'd30);
      checkOutput("stall_wb_dest", 64'(wb_dest), 64'd5);
      checkOutput("stall_wb_hi", 64'(wb_hi), 64'd0);
      checkOutput("stall_req_ready", 64'(req_ready), 64'd0);
      if (i == 1) begin
        req_opcode = OP_SUB;
        req_a      = 32'd99;
        req_b      = 32'd1;
        req_dest   = 4'd9;
        req_valid  = 1'b1;
      end
      if (i == 2) req_valid = 1'b0;
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    wb_ready = 1'b1;
    waitIdle();
    checkOutput("stall_no_latch_a", 64'(alu_a), 64'd10);
    checkOutput("stall_no_latch_op", 64'(alu_opcode), 64'(OP_ADD));

    // nop -> no beat, ready again at N+2
    applyStimulus(OP_NOP, 1'b0, 32'd1, 32'd2, 4'd6);
    @(negedge clock);
    checkOutput("nop_exec_busy", 64'(busy), 64'd1);
    @(negedge clock);
    checkOutput("nop_wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("nop_ready_n2", 64'(req_ready), 64'd1);

    // incpc with mul opcode -> single beat a+1
    pushBeat(32'h21, 4'd7, 1'b0);
    applyStimulus(OP_MUL, 1'b1, 32'h20, 32'd3, 4'd7);
    @(negedge clock);
    checkOutput("incpc_exec", 64'(alu_incpc), 64'd1);
    waitIdle();
    checkOutput("incpc_idle", 64'(alu_incpc), 64'd0);

    // unrecognised opcode -> single beat of zero despite ALU garbage
    pushBeat(32'd0, 4'd8, 1'b0);
    applyStimulus(5'b11111, 1'b0, 32'h1234, 32'h5678, 4'd8);
    waitIdle();

    // clear during WB_HI of div -> immediate reset, no HI beat afterwards
    pushBeat(32'd3, 4'd9, 1'b0);
    applyStimulus(OP_DIV, 1'b0, 32'd17, 32'd5, 4'd9);
    @(negedge clock);
    @(negedge clock);
    @(posedge clock);
    #1;
    wb_ready = 1'b0;
    @(negedge clock);
    checkOutput("clr_pre_hi", 64'(wb_hi), 64'd1);
    checkOutput("clr_pre_data", 64'(wb_data), 64'd2);
    #1;
    clear = 1'b1;
    #1;
    checkOutput("clr_wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("clr_alu_opcode", 64'(alu_opcode), 64'(OP_NOP));
    checkOutput("clr_busy", 64'(busy), 64'd0);
    checkOutput("clr_req_ready", 64'(req_ready), 64'd1);
    checkOutput("clr_wb_data", 64'(wb_data), 64'd0);
    @(posedge clock);
    #1;
    clear    = 1'b0;
    wb_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput("clr_after_wb_valid", 64'(wb_valid), 64'd0);
    end
    checkOutput("clr_after_busy", 64'(busy), 64'd0);

    checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
